// File: rtl/ldpc_channel_err_inj.sv
// Channel error injector: flips codeword bits from a 32-bit Galois LFSR against a threshold,
// then launches the decoder. Define LDPC_ERRINJ_MAXFLIP_EN to cap flips per frame at max_flips.
module ldpc_channel_err_inj #(
  parameter int NN    = 208,
  parameter int CNT_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [NN-1:0]    cword_in,
  input  logic             cword_valid,
  input  logic [31:0]      prob_thresh,
  input  logic [31:0]      seed,
  input  logic             seed_load,
  input  logic [CNT_W-1:0] max_flips,
  input  logic             dec_done,
  output logic [NN-1:0]    q0_1,
  output logic [NN-1:0]    q0_0,
  output logic             start_dec,
  output logic             busy,
  output logic [CNT_W-1:0] flip_cnt,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [31:0]      LFSR_MASK = 32'h8020_0003;
  localparam int               IDX_W     = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE,
    INJECT,
    LAUNCH,
    WAIT_DEC
  } state_t;

  state_t           state;
  logic [NN-1:0]    shift_buf;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] run_cnt;
  logic [31:0]      lfsr;
  logic             hit;
  logic             flip_ok;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    lfsr_step = v[0] ? ({1'b0, v[31:1]} ^ LFSR_MASK) : {1'b0, v[31:1]};
  endfunction

  assign hit  = (lfsr <= prob_thresh);
  assign busy = (state != IDLE);

`ifdef LDPC_ERRINJ_MAXFLIP_EN
  assign flip_ok = hit && (run_cnt != max_flips);
`else
  logic unused_max_flips;
  assign unused_max_flips = ^max_flips;
  assign flip_ok          = hit;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      q0_1      <= '0;
      q0_0      <= '1;
      start_dec <= 1'b0;
      flip_cnt  <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
      run_cnt   <= '0;
      bit_idx   <= '0;
      lfsr      <= 32'h0000_0001;
    end else begin
      start_dec <= 1'b0;

      // A zero seed would lock the LFSR, so it is mapped to 1.
      if (seed_load)
        lfsr <= (seed == 32'h0) ? 32'h0000_0001 : seed;
      else if (state == INJECT)
        lfsr <= lfsr_step(lfsr);

      if (cword_valid && (state != IDLE) && (drop_cnt != CNT_MAX))
        drop_cnt <= drop_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (cword_valid) begin
            run_cnt <= '0;
            bit_idx <= '0;
            state   <= INJECT;
          end
        end
        INJECT: begin
          if (flip_ok && (run_cnt != CNT_MAX))
            run_cnt <= run_cnt + 1'b1;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == LAST_IDX)
            state <= LAUNCH;
        end
        LAUNCH: begin
          q0_1      <= shift_buf;
          q0_0      <= ~shift_buf;
          flip_cnt  <= run_cnt;
          start_dec <= 1'b1;
          if (frame_cnt != CNT_MAX)
            frame_cnt <= frame_cnt + 1'b1;
          state     <= WAIT_DEC;
        end
        WAIT_DEC: begin
          if (dec_done)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the shift buffer is pure datapath, always fully reloaded before use, so it carries no reset.
  // Bit k leaves at position 0 and re-enters at the top; after NN shifts it is back at position k.
  always_ff @(posedge wb_clk_i) begin
    if ((state == IDLE) && cword_valid)
      shift_buf <= cword_in;
    else if (state == INJECT)
      shift_buf <= {shift_buf[0] ^ flip_ok, shift_buf[NN-1:1]};
  end

endmodule

// File: tb/tb_ldpc_channel_err_inj.sv
// Scoreboard bench for ldpc_channel_err_inj: stimulus pushes model results, a monitor checks launches.
module tb_ldpc_channel_err_inj;

  localparam int          NN    = 208;
  localparam int          CNT_W = 16;
  localparam logic [31:0] POLY  = 32'h8020_0003;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i;
  logic [NN-1:0]    cword_in;
  logic             cword_valid;
  logic [31:0]      prob_thresh;
  logic [31:0]      seed;
  logic             seed_load;
  logic [CNT_W-1:0] max_flips;
  logic             dec_done;
  logic [NN-1:0]    q0_1;
  logic [NN-1:0]    q0_0;
  logic             start_dec;
  logic             busy;
  logic [CNT_W-1:0] flip_cnt;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] drop_cnt;

  ldpc_channel_err_inj #(.NN(NN), .CNT_W(CNT_W)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .cword_in    (cword_in),
    .cword_valid (cword_valid),
    .prob_thresh (prob_thresh),
    .seed        (seed),
    .seed_load   (seed_load),
    .max_flips   (max_flips),
    .dec_done    (dec_done),
    .q0_1        (q0_1),
    .q0_0        (q0_0),
    .start_dec   (start_dec),
    .busy        (busy),
    .flip_cnt    (flip_cnt),
    .frame_cnt   (frame_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [NN-1:0] q;
    int            flips;
    int            frame;
    int            launch_edge;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [NN-1:0] hold_q = '0;
  logic [31:0]   m_lfsr = 32'h1;
  int            m_frames = 0;
  int            m_drops  = 0;
  int            edge_cnt = 0;
  int            checks   = 0;
  int            errors   = 0;

  always @(posedge wb_clk_i) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [NN-1:0] got, input logic [NN-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Reference: walk the frame bit by bit with the LFSR sequence, flipping where value <= threshold.
  function automatic void model_frame(input logic [NN-1:0] cw, input logic [31:0] thr,
                                      input logic [CNT_W-1:0] mf,
                                      output logic [NN-1:0] q, output int n);
    bit allow;
    q = cw;
    n = 0;
    for (int k = 0; k < NN; k++) begin
      allow = (m_lfsr <= thr);
`ifdef LDPC_ERRINJ_MAXFLIP_EN
      if (n >= int'(mf)) allow = 1'b0;
`endif
      if (allow) begin
        q[k] = ~q[k];
        n++;
      end
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? POLY : 32'h0);
    end
  endfunction

  function automatic logic [NN-1:0] rand_cw();
    logic [NN-1:0] w;
    for (int i = 0; i < NN; i++) w[i] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  // Monitor: every launch is compared with the oldest expectation; outputs must hold in between.
  always begin
    @(posedge wb_clk_i);
    #1;
    if (start_dec) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL start_dec_unexpected: got 1, want 0 at edge %0d", edge_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        check("q0_1", q0_1, mon_e.q);
        check("q0_0", q0_0, ~mon_e.q);
        check("flip_cnt", NN'(flip_cnt), NN'(mon_e.flips));
        check("frame_cnt", NN'(frame_cnt), NN'(mon_e.frame));
        check("launch_edge", NN'(edge_cnt), NN'(mon_e.launch_edge));
        hold_q = mon_e.q;
      end
    end else begin
      check("q0_1_hold", q0_1, hold_q);
      check("q0_0_hold", q0_0, ~hold_q);
    end
  end

  task automatic do_reset(input int n);
    @(negedge wb_clk_i);
    wb_rst_i    = 1'b1;
    cword_valid = 1'b0;
    dec_done    = 1'b0;
    seed_load   = 1'b0;
    hold_q      = '0;
    exp_q.delete();
    m_lfsr      = 32'h1;
    m_frames    = 0;
    m_drops     = 0;
    repeat (n) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_busy", NN'(busy), NN'(1'b0));
    check("rst_start_dec", NN'(start_dec), NN'(1'b0));
    check("rst_q0_1", q0_1, '0);
    check("rst_q0_0", q0_0, '1);
    check("rst_flip_cnt", NN'(flip_cnt), '0);
    check("rst_frame_cnt", NN'(frame_cnt), '0);
    check("rst_drop_cnt", NN'(drop_cnt), '0);
  endtask

  task automatic load_seed(input logic [31:0] s);
    @(negedge wb_clk_i);
    seed      = s;
    seed_load = 1'b1;
    @(negedge wb_clk_i);
    seed_load = 1'b0;
    m_lfsr    = (s == 32'h0) ? 32'h1 : s;
  endtask

  task automatic run_frame(input logic [NN-1:0] cw, input logic [31:0] thr,
                           input logic [CNT_W-1:0] mf, input bit drop_inject, input bit drop_wait);
    exp_t          e;
    logic [NN-1:0] q;
    int            n;
    bit            seen;
    @(negedge wb_clk_i);
    prob_thresh = thr;
    max_flips   = mf;
    cword_in    = cw;
    cword_valid = 1'b1;
    model_frame(cw, thr, mf, q, n);
    m_frames++;
    e.q           = q;
    e.flips       = n;
    e.frame       = m_frames;
    e.launch_edge = edge_cnt + NN + 2;
    exp_q.push_back(e);
    @(negedge wb_clk_i);
    cword_valid = 1'b0;
    cword_in    = rand_cw();
    check("busy_after_valid", NN'(busy), NN'(1'b1));
    // A stray dec_done while injecting must be ignored.
    repeat (9) @(negedge wb_clk_i);
    dec_done = 1'b1;
    @(negedge wb_clk_i);
    dec_done = 1'b0;
    if (drop_inject) begin
      repeat (29) @(negedge wb_clk_i);
      cword_valid = 1'b1;
      cword_in    = rand_cw();
      m_drops++;
      @(negedge wb_clk_i);
      cword_valid = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < NN + 10 && !seen; i++) begin
      @(negedge wb_clk_i);
      seen = start_dec;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL start_dec_timeout: got no pulse, want one within %0d cycles", NN + 10);
    end
    if (drop_wait) begin
      cword_valid = 1'b1;
      cword_in    = rand_cw();
      m_drops++;
      @(negedge wb_clk_i);
      cword_valid = 1'b0;
    end
    repeat ($urandom_range(0, 4)) @(negedge wb_clk_i);
    check("busy_wait_dec", NN'(busy), NN'(1'b1));
    dec_done = 1'b1;
    @(negedge wb_clk_i);
    dec_done = 1'b0;
    check("busy_idle", NN'(busy), NN'(1'b0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NN-1:0] cw;
    logic [NN-1:0] a5;
    wb_rst_i    = 1'b1;
    cword_in    = '0;
    cword_valid = 1'b0;
    prob_thresh = '0;
    seed        = '0;
    seed_load   = 1'b0;
    max_flips   = '0;
    dec_done    = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check_reset_state();

    for (int i = 0; i < NN / 8; i++) a5[i*8 +: 8] = 8'hA5;
    run_frame(a5, 32'h0, CNT_W'(0), 1'b0, 1'b0);
    run_frame(rand_cw(), 32'hFFFF_FFFF, CNT_W'(NN), 1'b0, 1'b0);

    cw = rand_cw();
    load_seed(32'h1234_5678);
    run_frame(cw, 32'h8000_0000, CNT_W'(NN), 1'b0, 1'b0);
    load_seed(32'h1234_5678);
    run_frame(cw, 32'h8000_0000, CNT_W'(NN), 1'b0, 1'b0);

    for (int f = 0; f < 8; f++) begin
      if (f == 2)
        load_seed(32'h0);
      else if ($urandom_range(0, 2) == 0)
        load_seed($urandom());
      run_frame(rand_cw(), $urandom() >> $urandom_range(0, 8), CNT_W'($urandom_range(0, 40)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check("drop_cnt_random", NN'(drop_cnt), NN'(m_drops));

    run_frame(rand_cw(), 32'hFFFF_FFFF, CNT_W'(5), 1'b0, 1'b0);
    run_frame(rand_cw(), 32'hFFFF_FFFF, CNT_W'(0), 1'b0, 1'b0);

    do_reset(2);
    check_reset_state();
    run_frame(rand_cw(), 32'h4000_0000, CNT_W'(NN), 1'b1, 1'b1);
    check("drop_cnt_two", NN'(drop_cnt), NN'(2));
    check("frame_cnt_one", NN'(frame_cnt), NN'(m_frames));
    check("q0_1_after_drops", q0_1, hold_q);

    // Abort a frame mid-injection: no launch may follow.
    @(negedge wb_clk_i);
    cword_in    = rand_cw();
    prob_thresh = 32'h8000_0000;
    cword_valid = 1'b1;
    @(negedge wb_clk_i);
    cword_valid = 1'b0;
    repeat (30) @(negedge wb_clk_i);
    do_reset(1);
    check_reset_state();
    repeat (NN + 10) @(negedge wb_clk_i);
    check("busy_after_abort", NN'(busy), NN'(1'b0));

    run_frame(rand_cw(), 32'h2000_0000, CNT_W'(NN), 1'b0, 1'b0);
    repeat (3) @(negedge wb_clk_i);
    check("exp_queue_drained", NN'(exp_q.size()), NN'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldpc_channel_err_inj.md
LDPC_CHANNEL_ERR_INJ -- requirements
Module: ldpc_channel_err_inj

Interface
REQ-001 SHALL have parameter NN, default 208 ('h0d0), codeword length in bits.
REQ-002 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-003 SHALL have port wb_clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port cword_in, input, NN, encoded codeword from the encoder wrapper (y_nr_enc).
REQ-006 SHALL have port cword_valid, input, 1, one-cycle pulse qualifying cword_in (valid_cword_enc).
REQ-007 SHALL have port prob_thresh, input, 32, flip threshold (p * 2^32, saturated).
REQ-008 SHALL have port seed, input, 32, LFSR seed value.
REQ-009 SHALL have port seed_load, input, 1, loads seed into the LFSR.
REQ-010 SHALL have port max_flips, input, CNT_W, cap on flipped bits per frame (see Configuration).
REQ-011 SHALL have port dec_done, input, 1, decoder finished (converged_loops_ended).
REQ-012 SHALL have port q0_1, output, NN, channel word after error injection.
REQ-013 SHALL have port q0_0, output, NN, bitwise complement of q0_1.
REQ-014 SHALL have port start_dec, output, 1, one-cycle decoder start pulse.
REQ-015 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-016 SHALL have port flip_cnt, output, CNT_W, number of bits flipped in the last frame.
REQ-017 SHALL have port frame_cnt, output, CNT_W, frames launched to the decoder.
REQ-018 SHALL have port drop_cnt, output, CNT_W, cword_valid pulses dropped while busy.

Function
REQ-019 SHALL implement FSM IDLE -> INJECT -> LAUNCH -> WAIT_DEC -> IDLE.
REQ-020 SHALL, in IDLE with cword_valid=1, capture cword_in into a shift buffer, clear the running flip count and bit index, and enter INJECT.
REQ-021 SHALL, in INJECT, process one bit per cycle: bit k is handled in the k-th INJECT cycle, starting at bit 0, NN cycles in total.
REQ-022 SHALL flip bit k iff the current LFSR value <= prob_thresh; the LFSR SHALL advance one step every INJECT cycle.
REQ-023 SHALL use a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1 (mask 0x80200003).
REQ-024 SHALL treat a loaded seed of 0 as 1 (the LFSR is never all-zero).
REQ-025 SHALL consequently produce no flips for prob_thresh=0 and flip every bit for prob_thresh=0xFFFFFFFF.
REQ-026 SHALL, after bit NN-1, enter LAUNCH.
REQ-027 SHALL, on the LAUNCH cycle, update q0_1, q0_0 and flip_cnt together, and assert start_dec for exactly that cycle.
REQ-028 SHALL increment frame_cnt on the LAUNCH cycle.
REQ-029 SHALL make start_dec rise NN+1 cycles after the cycle that sampled cword_valid.
REQ-030 SHALL hold q0_1 and q0_0 stable from LAUNCH until the next LAUNCH.
REQ-031 SHALL stay in WAIT_DEC until dec_done=1, then return to IDLE on the next cycle.
REQ-032 SHALL ignore dec_done in every state other than WAIT_DEC.
REQ-033 SHALL, on cword_valid in any state other than IDLE, drop the frame and increment drop_cnt; the current frame is unaffected.
REQ-034 SHALL saturate frame_cnt, drop_cnt and flip_cnt at all-ones (no wrap).
REQ-035 SHALL give seed_load priority over LFSR stepping when both occur in the same cycle; seed_load is legal in any state.

Reset
REQ-036 SHALL, while wb_rst_i is sampled high, force: state IDLE; q0_1 = 0 and q0_0 = all-ones; start_dec = 0; busy = 0; all counters = 0; LFSR = 0x00000001.
REQ-037 SHALL abort any frame in progress on reset mid-operation, with no start_dec pulse afterwards.

Configuration
REQ-038 SHALL, with LDPC_ERRINJ_MAXFLIP_EN defined, suppress further flips in a frame once the running flip count equals max_flips (the LFSR keeps stepping); max_flips=0 means no flips.
REQ-039 SHALL, with LDPC_ERRINJ_MAXFLIP_EN undefined, ignore max_flips and leave the number of flips uncapped.

Verification
REQ-040 SHALL cover: prob_thresh=0, cword_in=0xA5 pattern, one cword_valid -> q0_1 equals cword_in, flip_cnt=0, start_dec pulses exactly once, 209 cycles after the valid.
REQ-041 SHALL cover: prob_thresh=0xFFFFFFFF -> q0_1 = ~cword_in, q0_0 = cword_in, flip_cnt=208.
REQ-042 SHALL cover: seed=0x1234_5678 loaded, prob_thresh=0x8000_0000, same frame run twice with a reseed between -> identical q0_1, and flip_cnt matching the reference-model LFSR.
REQ-043 SHALL cover: a second cword_valid during INJECT and another during WAIT_DEC -> drop_cnt=2, frame_cnt=1, first-frame output unchanged.
REQ-044 SHALL cover: with LDPC_ERRINJ_MAXFLIP_EN defined, max_flips=5 and prob_thresh=0xFFFFFFFF -> only bits 0..4 flipped, flip_cnt=5.
REQ-045 SHALL cover: wb_rst_i asserted for 1 cycle mid-INJECT -> busy=0 next cycle, no start_dec, all counters=0, q0_0 all-ones.
